spi_ram: RTL and testbench

SPI_RAM -- requirements
Module: spi_ram

---
 rtl/spi_ram.sv | 132 +++++++++++++
 tb/tb_spi_ram.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram.sv
// spi_ram: single-port byte RAM driven by 10-bit command words from an SPI
// slave front end. din[9:8] is the opcode, din[7:0] the payload:
//   00 load write address   01 write data at write address
//   10 load read address    11 read data at read address into dout
// Data commands issued before their address has been loaded are rejected
// and flagged on err for one cycle.
// Optional feature: define SPI_RAM_AUTO_INC_EN to post-increment the
// relevant address (wrapping MEM_DEPTH-1 -> 0) after every accepted data
// command. Without it, addresses change only on their load opcodes.
module spi_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid,
  output logic       err
);

  // Handshake: rx_valid qualifies din for exactly one cycle and there is no
  // ready -- every qualified word is consumed at that clock edge. tx_valid is
  // a level, not a pulse: dout holds the last read byte and tx_valid stays
  // high until an accepted 00/01/10 command or reset; another accepted 11
  // reloads dout and keeps tx_valid high.

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  logic [7:0]           r_mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] r_wr_addr;
  logic [ADDR_SIZE-1:0] r_rd_addr;
  logic                 r_wa_vld;
  logic                 r_ra_vld;
  logic [7:0]           r_dout;
  logic                 r_tx_valid;
  logic                 r_err;

  logic [1:0]           w_op;
  logic [7:0]           w_payload;
  logic [ADDR_SIZE-1:0] w_addr;
  logic                 w_wr_ok;
  logic                 w_rd_ok;
  logic                 w_reject;
  logic [ADDR_SIZE-1:0] w_wr_addr_next;
  logic [ADDR_SIZE-1:0] w_rd_addr_next;

  // Command decode: split the word and classify it as accepted or rejected.
  always_comb begin
    w_op      = din[9:8];
    w_payload = din[7:0];
    w_addr    = din[ADDR_SIZE-1:0];
    w_wr_ok   = rx_valid && (w_op == OP_WR_DATA) && r_wa_vld;
    w_rd_ok   = rx_valid && (w_op == OP_RD_DATA) && r_ra_vld;
    w_reject  = rx_valid && (((w_op == OP_WR_DATA) && !r_wa_vld) ||
                             ((w_op == OP_RD_DATA) && !r_ra_vld));
  end

`ifdef SPI_RAM_AUTO_INC_EN
  // Post-increment addresses, wrapping at the top of the memory.
  always_comb begin
    w_wr_addr_next = (r_wr_addr == ADDR_SIZE'(MEM_DEPTH - 1)) ? '0
                     : r_wr_addr + ADDR_SIZE'(1);
    w_rd_addr_next = (r_rd_addr == ADDR_SIZE'(MEM_DEPTH - 1)) ? '0
                     : r_rd_addr + ADDR_SIZE'(1);
  end
`else
  // Addresses stay put after data commands.
  always_comb begin
    w_wr_addr_next = r_wr_addr;
    w_rd_addr_next = r_rd_addr;
  end
`endif

  // Memory array: no reset so it maps onto RAM; reset blocks the write.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_ok) begin
      r_mem[r_wr_addr] <= w_payload;
    end
  end

  // Control state, read data register and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_addr  <= '0;
      r_rd_addr  <= '0;
      r_wa_vld   <= 1'b0;
      r_ra_vld   <= 1'b0;
      r_dout     <= 8'h00;
      r_tx_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_reject;
      if (rx_valid) begin
        case (w_op)
          OP_WR_ADDR: begin
            r_wr_addr  <= w_addr;
            r_wa_vld   <= 1'b1;
            r_tx_valid <= 1'b0;
          end
          OP_WR_DATA: begin
            if (w_wr_ok) begin
              r_wr_addr  <= w_wr_addr_next;
              r_tx_valid <= 1'b0;
            end
          end
          OP_RD_ADDR: begin
            r_rd_addr  <= w_addr;
            r_ra_vld   <= 1'b1;
            r_tx_valid <= 1'b0;
          end
          default: begin
            if (w_rd_ok) begin
              r_dout     <= r_mem[r_rd_addr];
              r_tx_valid <= 1'b1;
              r_rd_addr  <= w_rd_addr_next;
            end
          end
        endcase
      end
    end
  end

  assign dout     = r_dout;
  assign tx_valid = r_tx_valid;
  assign err      = r_err;

endmodule

// File: tb/tb_spi_ram.sv
// tb_spi_ram: directed vector table, hand-written corner sequences and a
// randomized run checked against a behavioural model of the command set.
module tb_spi_ram;

  localparam int MEM_DEPTH = 256;
  localparam int ADDR_SIZE = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout;
  logic       tx_valid;
  logic       err;

  int errors = 0;
  int checks = 0;

  spi_ram #(.MEM_DEPTH(MEM_DEPTH), .ADDR_SIZE(ADDR_SIZE)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .rx_valid (rx_valid),
    .dout     (dout),
    .tx_valid (tx_valid),
    .err      (err)
  );

  // Clock and reset defaults
  always #5 clk = ~clk;
  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    din      = 10'h000;
  end

  // Behavioural model: memory image plus the architectural registers
  logic [7:0] m_mem   [MEM_DEPTH];
  bit         m_known [MEM_DEPTH];
  int         m_wr, m_rd;
  bit         m_wa, m_ra;
  logic [7:0] m_dout;
  bit         m_dout_known;
  bit         m_tx, m_err;

  function automatic int next_addr(int a);
`ifdef SPI_RAM_AUTO_INC_EN
    return (a + 1) % MEM_DEPTH;
`else
    return a;
`endif
  endfunction

  task automatic model_step(input bit r, input bit v, input logic [9:0] d);
    int op, p;
    op = int'(d[9:8]);
    p  = int'(d[7:0]) % MEM_DEPTH;
    if (r) begin
      m_dout = 8'h00; m_dout_known = 1'b1; m_tx = 1'b0; m_err = 1'b0;
      m_wr = 0; m_rd = 0; m_wa = 1'b0; m_ra = 1'b0;
    end else begin
      m_err = 1'b0;
      if (v) begin
        if (op == 0) begin
          m_wr = p; m_wa = 1'b1; m_tx = 1'b0;
        end else if (op == 2) begin
          m_rd = p; m_ra = 1'b1; m_tx = 1'b0;
        end else if (op == 1) begin
          if (m_wa) begin
            m_mem[m_wr] = d[7:0]; m_known[m_wr] = 1'b1;
            m_wr = next_addr(m_wr); m_tx = 1'b0;
          end else m_err = 1'b1;
        end else begin
          if (m_ra) begin
            m_dout = m_mem[m_rd]; m_dout_known = m_known[m_rd];
            m_rd = next_addr(m_rd); m_tx = 1'b1;
          end else m_err = 1'b1;
        end
      end
    end
  endtask

  // Scoreboard comparison
  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Driver: one command per cycle, then compare against the model
  task automatic apply(input bit r, input bit v, input logic [9:0] d);
    @(negedge clk);
    rst = r; rx_valid = v; din = d;
    model_step(r, v, d);
    @(posedge clk);
    #1;
    check("model_tx_valid", {7'd0, tx_valid}, {7'd0, m_tx});
    check("model_err", {7'd0, err}, {7'd0, m_err});
    if (m_dout_known) check("model_dout", dout, m_dout);
  endtask

  typedef struct {
    bit         rst;
    bit         vld;
    logic [9:0] din;
    bit         exp_tx;
    bit         exp_err;
    bit         chk_dout;
    logic [7:0] exp_dout;
  } vec_t;

  function automatic vec_t mk(bit r, bit v, logic [9:0] d, bit tx, bit e, bit cd, logic [7:0] dd);
    vec_t x;
    x.rst = r; x.vld = v; x.din = d; x.exp_tx = tx; x.exp_err = e;
    x.chk_dout = cd; x.exp_dout = dd;
    return x;
  endfunction

  vec_t vecs[14];
  logic [7:0] exp_b;
  logic [7:0] held;

  initial begin
    for (int i = 0; i < MEM_DEPTH; i++) m_known[i] = 1'b0;

    // Directed table: write/read, hold, reload, reset priority, rejects
    vecs[0]  = mk(1, 0, 10'h000, 0, 0, 1, 8'h00);
    vecs[1]  = mk(0, 1, 10'h02A, 0, 0, 1, 8'h00);
    vecs[2]  = mk(0, 1, 10'h1C3, 0, 0, 1, 8'h00);
    vecs[3]  = mk(0, 1, 10'h22A, 0, 0, 1, 8'h00);
    vecs[4]  = mk(0, 1, 10'h300, 1, 0, 1, 8'hC3);
    vecs[5]  = mk(0, 0, 10'h3FF, 1, 0, 1, 8'hC3);
    vecs[6]  = mk(0, 1, 10'h22A, 0, 0, 0, 8'h00);
    vecs[7]  = mk(0, 1, 10'h300, 1, 0, 1, 8'hC3);
    vecs[8]  = mk(1, 1, 10'h300, 0, 0, 1, 8'h00);
    vecs[9]  = mk(0, 1, 10'h155, 0, 1, 1, 8'h00);
    vecs[10] = mk(0, 0, 10'h000, 0, 0, 1, 8'h00);
    vecs[11] = mk(0, 1, 10'h300, 0, 1, 1, 8'h00);
    vecs[12] = mk(0, 0, 10'h3FF, 0, 0, 1, 8'h00);
    vecs[13] = mk(0, 1, 10'h0AA, 0, 0, 1, 8'h00);

    apply(1, 0, 10'h000);
    for (int i = 0; i < 14; i++) begin
      apply(vecs[i].rst, vecs[i].vld, vecs[i].din);
      check($sformatf("vec%0d_tx_valid", i), {7'd0, tx_valid}, {7'd0, vecs[i].exp_tx});
      check($sformatf("vec%0d_err", i), {7'd0, err}, {7'd0, vecs[i].exp_err});
      if (vecs[i].chk_dout) check($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
    end

    // A rejected write after reset must not disturb memory
    apply(0, 1, 10'h000);
    apply(0, 1, 10'h1AB);
    apply(1, 0, 10'h000);
    apply(0, 1, 10'h155);
    check("reject_wr_err", {7'd0, err}, 8'd1);
    apply(0, 1, 10'h200);
    apply(0, 1, 10'h300);
    check("reject_wr_mem", dout, 8'hAB);
    check("reject_wr_tx", {7'd0, tx_valid}, 8'd1);

    // Consecutive writes: auto-increment vs fixed address, with wrap
    apply(0, 1, 10'h0FF);
    apply(0, 1, 10'h111);
    apply(0, 1, 10'h122);
    apply(0, 1, 10'h2FF);
    apply(0, 1, 10'h300);
`ifdef SPI_RAM_AUTO_INC_EN
    exp_b = 8'h11;
`else
    exp_b = 8'h22;
`endif
    check("inc_mem_ff", dout, exp_b);
    apply(0, 1, 10'h200);
    apply(0, 1, 10'h300);
`ifdef SPI_RAM_AUTO_INC_EN
    held = 8'h22;
`else
    held = 8'hAB;
`endif
    check("inc_mem_00", dout, held);

    // Idle with din toggling: nothing may move
    for (int i = 0; i < 20; i++) begin
      apply(0, 0, (i % 2) ? 10'h3FF : 10'h000);
      check("idle_dout", dout, held);
      check("idle_tx", {7'd0, tx_valid}, 8'd1);
      check("idle_err", {7'd0, err}, 8'd0);
    end
    apply(0, 1, 10'h2FF);
    apply(0, 1, 10'h300);
    check("idle_mem_ff", dout, exp_b);

    // Randomized commands against the model
    for (int i = 0; i < 3000; i++) begin
      logic [9:0] d;
      bit r, v;
      r = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 9) < 7);
      d[9:8] = 2'($urandom_range(0, 3));
      if (d[9:8] == 2'b00 || d[9:8] == 2'b10) d[7:0] = 8'($urandom_range(0, 15)) | ($urandom_range(0, 7) == 0 ? 8'hF0 : 8'h00);
      else d[7:0] = 8'($urandom);
      apply(r, v, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
